// File: rtl/mul_div_unit_if.sv
// Request/response bus of the iterative multiply/divide unit.
interface mul_div_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    // Issuing side: presents requests and accepts results.
    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    // Execution unit side.
    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 shift-add multiplier / restoring divider with
// valid/ready handshake, flush abort and held result.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    mul_div_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MOD   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MODU  = 3'd6;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q,      state_d;
    logic [PW-1:0]    acc_q,        acc_d;        // {hi: partial product / remainder, lo: multiplier / quotient}
    logic [WIDTH-1:0] opb_q,        opb_d;        // multiplicand or divisor magnitude
    logic [2:0]       op_q,         op_d;
    logic [TAG_W-1:0] tag_q,        tag_d;
    logic             neg_q,        neg_d;
    logic             spec_q,       spec_d;
    logic [WIDTH-1:0] spec_val_q,   spec_val_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;

    logic             in_ready_c;
    logic             in_signed_c, in_is_div_c, in_is_rem_c;
    logic             s1_neg_c, s2_neg_c, div_zero_c, div_ovf_c;
    logic [WIDTH-1:0] mag1_c, mag2_c, spec_val_c;

    logic [WIDTH:0]   mul_sum_c, div_trial_c, div_diff_c;
    logic [PW-1:0]    mul_next_c, div_next_c, acc_neg_c;
    logic [WIDTH-1:0] quo_c, rem_c, final_c;
    logic             op_is_div_c;

    assign in_ready_c     = (state_q == S_IDLE) && !flush && !reset;
    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;

    // Request decode: operand magnitudes, result sign and special-case override.
    always_comb begin
        in_signed_c = (bus.in_op == OP_MULH) || (bus.in_op == OP_DIV) || (bus.in_op == OP_MOD);
        in_is_div_c = (bus.in_op == OP_DIV) || (bus.in_op == OP_MOD) ||
                      (bus.in_op == OP_DIVU) || (bus.in_op == OP_MODU);
        in_is_rem_c = (bus.in_op == OP_MOD) || (bus.in_op == OP_MODU);
        s1_neg_c    = in_signed_c && bus.in_src1[WIDTH-1];
        s2_neg_c    = in_signed_c && bus.in_src2[WIDTH-1];
        mag1_c      = s1_neg_c ? ((~bus.in_src1) + WIDTH'(1)) : bus.in_src1;
        mag2_c      = s2_neg_c ? ((~bus.in_src2) + WIDTH'(1)) : bus.in_src2;
        div_zero_c  = in_is_div_c && (bus.in_src2 == '0);
        div_ovf_c   = ((bus.in_op == OP_DIV) || (bus.in_op == OP_MOD)) &&
                      (bus.in_src1 == MIN_NEG) && (bus.in_src2 == '1);
        if (div_zero_c) begin
            spec_val_c = in_is_rem_c ? bus.in_src1 : '1;
        end else begin
            spec_val_c = in_is_rem_c ? '0 : MIN_NEG;
        end
    end

    // One radix-2 step of each algorithm plus final sign fix-up.
    always_comb begin
        op_is_div_c = (op_q == OP_DIV) || (op_q == OP_MOD) ||
                      (op_q == OP_DIVU) || (op_q == OP_MODU);
        mul_sum_c   = {1'b0, acc_q[PW-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next_c  = {mul_sum_c, acc_q[WIDTH-1:1]};
        div_trial_c = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_c  = div_trial_c - {1'b0, opb_q};
        div_next_c  = div_diff_c[WIDTH] ? {div_trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_diff_c[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        acc_neg_c   = (~acc_q) + PW'(1);
        quo_c       = neg_q ? acc_neg_c[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_c       = neg_q ? ((~acc_q[PW-1:WIDTH]) + WIDTH'(1)) : acc_q[PW-1:WIDTH];
        case (op_q)
            OP_MULH:          final_c = neg_q ? acc_neg_c[PW-1:WIDTH] : acc_q[PW-1:WIDTH];
            OP_MULHU:         final_c = acc_q[PW-1:WIDTH];
            OP_DIV, OP_DIVU:  final_c = quo_c;
            OP_MOD, OP_MODU:  final_c = rem_c;
            default:          final_c = acc_q[WIDTH-1:0];
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        opb_d        = opb_q;
        op_d         = op_q;
        tag_d        = tag_q;
        neg_d        = neg_q;
        spec_d       = spec_q;
        spec_val_d   = spec_val_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_c) begin
                    op_d       = bus.in_op;
                    tag_d      = bus.in_tag;
                    neg_d      = in_is_rem_c ? s1_neg_c : (s1_neg_c ^ s2_neg_c);
                    spec_d     = div_zero_c || div_ovf_c;
                    spec_val_d = spec_val_c;
                    cnt_d      = '0;
                    if (in_is_div_c) begin
                        acc_d = {{WIDTH{1'b0}}, mag1_c};
                        opb_d = mag2_c;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag2_c};
                        opb_d = mag1_c;
                    end
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    out_result_d = spec_q ? spec_val_q : final_c;
                    out_tag_d    = tag_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    acc_d = op_is_div_c ? div_next_c : mul_next_c;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            neg_q        <= 1'b0;
            spec_q       <= 1'b0;
            spec_val_q   <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            neg_q        <= neg_d;
            spec_q       <= spec_d;
            spec_val_q   <= spec_val_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end
endmodule
